// File: rtl/sccb_mon_pkg.sv
// Shared definitions for the SCCB bus monitor.
// Contents:
//   mon_state_t : byte deframer states (IDLE, BITS, ACK).
//   REC_*       : bit positions inside one FIFO record.
//   make_rec    : packs the record fields into a REC_W-bit word.
package sccb_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BITS = 2'd1,
        ACK  = 2'd2
    } mon_state_t;

    localparam int REC_W        = 11;
    localparam int REC_FIRST    = 10;
    localparam int REC_REP      = 9;
    localparam int REC_ACK      = 8;
    localparam int REC_DATA_MSB = 7;

    function automatic logic [REC_W-1:0] make_rec(input logic       first,
                                                  input logic       rep,
                                                  input logic       ack,
                                                  input logic [7:0] data);
        logic [REC_W-1:0] r;
        r                          = '0;
        r[REC_FIRST]               = first;
        r[REC_REP]                 = rep;
        r[REC_ACK]                 = ack;
        r[REC_DATA_MSB -: 8]       = data;
        return r;
    endfunction

endpackage

// File: rtl/sccb_sync_filter.sv
// Synchroniser plus stability filter for one asynchronous bus line.
// The filtered output follows the synchronised level only after the two have
// disagreed for FILT_LEN consecutive cycles, so shorter pulses are removed.
// Pin-to-output latency is SYNC_STAGES + FILT_LEN cycles.
// Ports:
//   ILA_clk : sampling clock
//   rstn    : asynchronous active-low reset (output resets to 1, bus idle)
//   din     : raw pin level
//   dout    : synchronised, glitch-filtered level
module sccb_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic ILA_clk,
    input  logic rstn,
    input  logic din,
    output logic dout
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          stab_cnt;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge ILA_clk or negedge rstn) begin
        if (!rstn) begin
            sync_q   <= '1;
            stab_cnt <= '0;
            dout     <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            if (synced == dout) begin
                stab_cnt <= '0;
            end else if (stab_cnt == CW'(FILT_LEN - 1)) begin
                // FILT_LEN-th consecutive cycle of disagreement
                dout     <= synced;
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sccb_bus_monitor.sv
// Passive SCCB/I2C bus monitor. Filters SCL/SDA, detects START / repeated
// START / STOP, deframes bytes plus the ACK bit and pushes one tagged record
// per byte into a show-ahead FIFO. Keeps saturating event counters and the
// last four completed bytes for debug readout.
// Ports:
//   ILA_clk, rstn          : clock, asynchronous active-low reset
//   enable                 : 1 = monitor active (filters always run)
//   clear                  : sync pulse, flush FIFO, zero counters/overflow/last_word
//   scl_in, sda_in         : raw bus pins
//   rd_en                  : pop FIFO head
//   rd_data                : head record {first, rep, ack, data[7:0]}
//   empty, fifo_count      : FIFO status
//   overflow               : sticky, a record was dropped on a full FIFO
//   busy                   : between START and STOP
//   start_cnt/byte_cnt/err_cnt : saturating counters
//   last_word              : last four bytes, newest in [7:0]
module sccb_bus_monitor
    import sccb_mon_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int CNT_W       = 16
) (
    input  logic                          ILA_clk,
    input  logic                          rstn,
    input  logic                          enable,
    input  logic                          clear,
    input  logic                          scl_in,
    input  logic                          sda_in,
    input  logic                          rd_en,
    output logic [REC_W-1:0]              rd_data,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          busy,
    output logic [CNT_W-1:0]              start_cnt,
    output logic [CNT_W-1:0]              byte_cnt,
    output logic [CNT_W-1:0]              err_cnt,
    output logic [31:0]                   last_word
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic scl, sda, scl_d, sda_d;
    logic scl_rise, start_ev, stop_ev;

    mon_state_t       state, state_n;
    logic [3:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift_q, shift_n;
    logic             first_q, first_n, rep_q, rep_n, busy_n;
    logic             partial;
    logic             push, inc_start, inc_byte, inc_err;
    logic [REC_W-1:0] rec;

    logic             push_p1;
    logic [REC_W-1:0] rec_p1;

    logic [REC_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             full, do_push, do_pop;

    // ---- stage 0: input conditioning ----
    sccb_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
        .ILA_clk (ILA_clk),
        .rstn    (rstn),
        .din     (scl_in),
        .dout    (scl)
    );

    sccb_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
        .ILA_clk (ILA_clk),
        .rstn    (rstn),
        .din     (sda_in),
        .dout    (sda)
    );

    assign scl_rise = scl & ~scl_d;
    assign start_ev = scl & scl_d & sda_d & ~sda;
    assign stop_ev  = scl & scl_d & ~sda_d & sda;

    // Every STOP and repeated START is preceded by one SCL rise that the
    // deframer cannot tell apart from a data bit, so a single sampled bit is
    // not treated as an abandoned byte.
    assign partial = (state == ACK) || (bit_idx > 4'd1);

    // ---- stage 1: deframer FSM ----
    always_comb begin
        state_n   = state;
        bit_idx_n = bit_idx;
        shift_n   = shift_q;
        first_n   = first_q;
        rep_n     = rep_q;
        busy_n    = busy;
        push      = 1'b0;
        inc_start = 1'b0;
        inc_byte  = 1'b0;
        inc_err   = 1'b0;
        rec       = make_rec(first_q, rep_q, sda, shift_q);

        if (!enable) begin
            state_n = IDLE;
            busy_n  = 1'b0;
        end else if (start_ev) begin
            inc_start = 1'b1;
            if (state != IDLE) begin
                inc_err = partial;
                rep_n   = 1'b1;
            end else begin
                rep_n   = 1'b0;
            end
            state_n   = BITS;
            bit_idx_n = 4'd0;
            busy_n    = 1'b1;
            first_n   = 1'b1;
        end else if (stop_ev) begin
            if (state != IDLE) begin
                inc_err = partial;
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        end else if (scl_rise) begin
            case (state)
                BITS: begin
                    shift_n   = {shift_q[6:0], sda};
                    bit_idx_n = bit_idx + 4'd1;
                    if (bit_idx == 4'd7) state_n = ACK;
                end
                ACK: begin
                    push      = 1'b1;
                    inc_byte  = 1'b1;
                    first_n   = 1'b0;
                    bit_idx_n = 4'd0;
                    state_n   = BITS;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ILA_clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            bit_idx <= '0;
            shift_q <= '0;
            first_q <= 1'b0;
            rep_q   <= 1'b0;
            busy    <= 1'b0;
            scl_d   <= 1'b1;
            sda_d   <= 1'b1;
            push_p1 <= 1'b0;
            rec_p1  <= '0;
        end else begin
            state   <= state_n;
            bit_idx <= bit_idx_n;
            shift_q <= shift_n;
            first_q <= first_n;
            rep_q   <= rep_n;
            busy    <= busy_n;
            scl_d   <= scl;
            sda_d   <= sda;
            // clear also kills a record still in flight to the FIFO
            push_p1 <= push & ~clear;
            rec_p1  <= rec;
        end
    end

    always_ff @(posedge ILA_clk or negedge rstn) begin
        if (!rstn) begin
            start_cnt <= '0;
            byte_cnt  <= '0;
            err_cnt   <= '0;
            last_word <= '0;
        end else if (clear) begin
            start_cnt <= '0;
            byte_cnt  <= '0;
            err_cnt   <= '0;
            last_word <= '0;
        end else begin
            if (inc_start) start_cnt <= sat_inc(start_cnt);
            if (inc_err)   err_cnt   <= sat_inc(err_cnt);
            if (inc_byte) begin
                byte_cnt  <= sat_inc(byte_cnt);
                last_word <= {last_word[23:0], shift_q};
            end
        end
    end

    // ---- stage 2: record FIFO ----
    assign empty   = (fifo_count == '0);
    assign full    = (fifo_count == FULL_CNT);
    assign do_pop  = rd_en & ~empty;
    assign do_push = push_p1 & (~full | do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge ILA_clk) begin
        if (do_push && !clear) mem[wr_ptr] <= rec_p1;
    end

    always_ff @(posedge ILA_clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
            if (push_p1 && !do_push) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sccb_bus_monitor.sv
// Scoreboard bench for sccb_bus_monitor. Bus stimulus pushes the expected
// record of every byte that should reach the FIFO; a separate monitor pops
// the FIFO whenever it is non-empty and compares against the queue.
module tb_sccb_bus_monitor;

    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 16;
    localparam int Q          = 10;   // quarter SCL period in clock cycles

    logic        ILA_clk = 1'b0;
    logic        rstn    = 1'b0;
    logic        enable  = 1'b1;
    logic        clear   = 1'b0;
    logic        scl_in  = 1'b1;
    logic        sda_in  = 1'b1;
    logic        mon_rd  = 1'b0;
    logic        stim_rd = 1'b0;
    logic        rd_en;
    logic [10:0] rd_data;
    logic        empty;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        busy;
    logic [CNT_W-1:0] start_cnt, byte_cnt, err_cnt;
    logic [31:0] last_word;

    int          checks = 0;
    int          errors = 0;
    logic [10:0] exp_q[$];
    bit          hold = 1'b0;

    assign rd_en = mon_rd | stim_rd;

    always #5 ILA_clk = ~ILA_clk;

    sccb_bus_monitor #(
        .SYNC_STAGES(2), .FILT_LEN(4), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .ILA_clk    (ILA_clk),
        .rstn       (rstn),
        .enable     (enable),
        .clear      (clear),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .busy       (busy),
        .start_cnt  (start_cnt),
        .byte_cnt   (byte_cnt),
        .err_cnt    (err_cnt),
        .last_word  (last_word)
    );

    function automatic logic [10:0] exp_rec(input logic f, input logic r,
                                            input logic a, input logic [7:0] d);
        return {f, r, a, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge ILA_clk);
    endtask

    task automatic pulse_clear();
        @(negedge ILA_clk);
        clear = 1'b1;
        @(negedge ILA_clk);
        clear = 1'b0;
        wait_neg(2);
    endtask

    task automatic send_start();
        scl_in = 1'b1; sda_in = 1'b1; wait_neg(Q);
        sda_in = 1'b0; wait_neg(Q);
        scl_in = 1'b0; wait_neg(Q);
    endtask

    task automatic send_rstart();
        sda_in = 1'b1; wait_neg(Q);
        scl_in = 1'b1; wait_neg(Q);
        sda_in = 1'b0; wait_neg(Q);
        scl_in = 1'b0; wait_neg(Q);
    endtask

    task automatic send_stop();
        sda_in = 1'b0; wait_neg(Q);
        scl_in = 1'b1; wait_neg(Q);
        sda_in = 1'b1; wait_neg(2*Q);
    endtask

    task automatic send_bit(input logic b);
        sda_in = b;    wait_neg(Q);
        scl_in = 1'b1; wait_neg(2*Q);
        scl_in = 1'b0; wait_neg(Q);
    endtask

    // act: 0 none, 1 clear on the 9th-bit push cycle, 2 pop on the push cycle
    task automatic send_byte(input logic [7:0] d, input logic ack, input bit expect_rec,
                             input logic f, input logic r, input int act);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        if (expect_rec) exp_q.push_back(exp_rec(f, r, ack, d));
        sda_in = ack; wait_neg(Q);
        scl_in = 1'b1;
        for (int i = 1; i <= 2*Q; i++) begin
            @(negedge ILA_clk);
            if (act == 1 && i == 6) begin
                clear = 1'b1;
                exp_q.delete();
            end
            if (act == 1 && i == 7) clear = 1'b0;
            if (act == 2 && i == 7) begin
                check("head popped during push", 32'(rd_data), 32'(exp_q.pop_front()));
                stim_rd = 1'b1;
            end
            if (act == 2 && i == 8) stim_rd = 1'b0;
        end
        scl_in = 1'b0; wait_neg(Q);
    endtask

    task automatic glitch(input int n);
        sda_in = 1'b0; wait_neg(n);
        sda_in = 1'b1; wait_neg(20);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge ILA_clk);
            n++;
        end
        wait_neg(3);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        check("empty after drain", 32'(empty), 32'd1);
    endtask

    // Scoreboard monitor: pop and compare every record the DUT presents.
    initial begin
        forever begin
            @(negedge ILA_clk);
            mon_rd = 1'b0;
            if (!hold && rstn && !empty) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected record: got 0x%0h, expected none", rd_data);
                end else begin
                    check("record", 32'(rd_data), 32'(exp_q.pop_front()));
                end
                mon_rd = 1'b1;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset state
        wait_neg(3);
        check("reset rd_data",    32'(rd_data),    32'd0);
        check("reset empty",      32'(empty),      32'd1);
        check("reset fifo_count", 32'(fifo_count), 32'd0);
        check("reset overflow",   32'(overflow),   32'd0);
        check("reset busy",       32'(busy),       32'd0);
        check("reset start_cnt",  32'(start_cnt),  32'd0);
        check("reset byte_cnt",   32'(byte_cnt),   32'd0);
        check("reset err_cnt",    32'(err_cnt),    32'd0);
        check("reset last_word",  last_word,       32'd0);
        rstn = 1'b1;
        wait_neg(20);

        // write 0x42 0x30 0x0A, all ACK
        send_start();
        send_byte(8'h42, 1'b0, 1, 1'b1, 1'b0, 0);
        check("busy mid transfer", 32'(busy), 32'd1);
        send_byte(8'h30, 1'b0, 1, 1'b0, 1'b0, 0);
        send_byte(8'h0A, 1'b0, 1, 1'b0, 1'b0, 0);
        send_stop();
        wait_neg(10);
        drain();
        check("write byte_cnt",  32'(byte_cnt),  32'd3);
        check("write start_cnt", 32'(start_cnt), 32'd1);
        check("write err_cnt",   32'(err_cnt),   32'd0);
        check("write last_word", last_word,      32'h0042300A);
        check("write busy",      32'(busy),      32'd0);
        pulse_clear();

        // read with repeated START, final byte NACK
        send_start();
        send_byte(8'h43, 1'b0, 1, 1'b1, 1'b0, 0);
        send_rstart();
        send_byte(8'h43, 1'b0, 1, 1'b1, 1'b1, 0);
        send_byte(8'hA5, 1'b1, 1, 1'b0, 1'b1, 0);
        send_stop();
        wait_neg(10);
        drain();
        check("read start_cnt", 32'(start_cnt), 32'd2);
        check("read err_cnt",   32'(err_cnt),   32'd0);
        check("read byte_cnt",  32'(byte_cnt),  32'd3);
        check("read last_word", last_word,      32'h004343A5);
        pulse_clear();

        // SDA glitches with SCL high
        glitch(2);
        glitch(2);
        glitch(3);
        check("short glitch start_cnt", 32'(start_cnt), 32'd0);
        check("short glitch busy",      32'(busy),      32'd0);
        check("short glitch empty",     32'(empty),     32'd1);
        glitch(4);
        check("4-cycle glitch start_cnt", 32'(start_cnt), 32'd1);
        check("4-cycle glitch err_cnt",   32'(err_cnt),   32'd0);
        check("4-cycle glitch busy",      32'(busy),      32'd0);
        check("4-cycle glitch empty",     32'(empty),     32'd1);
        pulse_clear();

        // STOP after 5 bits, then a clean byte
        send_start();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        send_stop();
        wait_neg(10);
        check("partial err_cnt",  32'(err_cnt),  32'd1);
        check("partial busy",     32'(busy),     32'd0);
        check("partial empty",    32'(empty),    32'd1);
        check("partial byte_cnt", 32'(byte_cnt), 32'd0);
        send_start();
        send_byte(8'h11, 1'b0, 1, 1'b1, 1'b0, 0);
        send_stop();
        wait_neg(10);
        drain();
        check("after partial err_cnt",  32'(err_cnt),  32'd1);
        check("after partial byte_cnt", 32'(byte_cnt), 32'd1);
        pulse_clear();

        // overflow with no reads, then clear on a 9th-bit push
        hold = 1'b1;
        send_start();
        send_byte(8'hA1, 1'b0, 1, 1'b1, 1'b0, 0);
        send_byte(8'hA2, 1'b0, 1, 1'b0, 1'b0, 0);
        send_byte(8'hA3, 1'b0, 1, 1'b0, 1'b0, 0);
        send_byte(8'hA4, 1'b0, 1, 1'b0, 1'b0, 0);
        check("full fifo_count", 32'(fifo_count), 32'd4);
        check("full overflow",   32'(overflow),   32'd0);
        send_byte(8'hA5, 1'b0, 0, 1'b0, 1'b0, 0);
        send_byte(8'hA6, 1'b0, 0, 1'b0, 1'b0, 0);
        check("ovf fifo_count", 32'(fifo_count), 32'd4);
        check("ovf overflow",   32'(overflow),   32'd1);
        check("ovf head",       32'(rd_data),    32'(exp_rec(1'b1, 1'b0, 1'b0, 8'hA1)));
        check("ovf byte_cnt",   32'(byte_cnt),   32'd6);
        check("ovf last_word",  last_word,       32'hA3A4A5A6);
        send_byte(8'hA7, 1'b0, 0, 1'b0, 1'b0, 1);
        check("clear empty",      32'(empty),      32'd1);
        check("clear fifo_count", 32'(fifo_count), 32'd0);
        check("clear overflow",   32'(overflow),   32'd0);
        check("clear byte_cnt",   32'(byte_cnt),   32'd0);
        check("clear start_cnt",  32'(start_cnt),  32'd0);
        check("clear last_word",  last_word,       32'd0);
        send_stop();
        wait_neg(10);
        check("clear err_cnt", 32'(err_cnt), 32'd0);
        check("clear busy",    32'(busy),    32'd0);

        // pop coinciding with the push into a full FIFO
        send_start();
        send_byte(8'hB1, 1'b0, 1, 1'b1, 1'b0, 0);
        send_byte(8'hB2, 1'b0, 1, 1'b0, 1'b0, 0);
        send_byte(8'hB3, 1'b0, 1, 1'b0, 1'b0, 0);
        send_byte(8'hB4, 1'b0, 1, 1'b0, 1'b0, 0);
        send_byte(8'hB5, 1'b0, 1, 1'b0, 1'b0, 2);
        check("push+pop fifo_count", 32'(fifo_count), 32'd4);
        check("push+pop overflow",   32'(overflow),   32'd0);
        send_stop();
        hold = 1'b0;
        drain();
        check("push+pop last_word", last_word,      32'hB2B3B4B5);
        check("push+pop byte_cnt",  32'(byte_cnt),  32'd5);
        check("push+pop start_cnt", 32'(start_cnt), 32'd1);

        // disabled during a full transfer
        enable = 1'b0;
        wait_neg(5);
        send_start();
        check("disabled busy", 32'(busy), 32'd0);
        send_byte(8'hC1, 1'b0, 0, 1'b1, 1'b0, 0);
        send_byte(8'hC2, 1'b0, 0, 1'b0, 1'b0, 0);
        send_stop();
        wait_neg(10);
        enable = 1'b1;
        wait_neg(10);
        check("disabled empty",     32'(empty),     32'd1);
        check("disabled start_cnt", 32'(start_cnt), 32'd1);
        check("disabled byte_cnt",  32'(byte_cnt),  32'd5);
        check("disabled err_cnt",   32'(err_cnt),   32'd0);
        check("disabled last_word", last_word,      32'hB2B3B4B5);

        // asynchronous reset mid-byte
        hold = 1'b1;
        send_start();
        send_byte(8'h5A, 1'b0, 1, 1'b1, 1'b0, 0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check("pre-reset fifo_count", 32'(fifo_count), 32'd1);
        @(negedge ILA_clk);
        #2 rstn = 1'b0;
        #1;
        check("async reset busy",       32'(busy),       32'd0);
        check("async reset empty",      32'(empty),      32'd1);
        check("async reset fifo_count", 32'(fifo_count), 32'd0);
        check("async reset start_cnt",  32'(start_cnt),  32'd0);
        check("async reset byte_cnt",   32'(byte_cnt),   32'd0);
        check("async reset last_word",  last_word,       32'd0);
        check("async reset rd_data",    32'(rd_data),    32'd0);
        exp_q.delete();
        scl_in = 1'b1;
        sda_in = 1'b1;
        wait_neg(5);
        rstn = 1'b1;
        hold = 1'b0;
        wait_neg(20);
        check("post-reset busy",  32'(busy),  32'd0);
        check("post-reset empty", 32'(empty), 32'd1);
        check("scoreboard leftover", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
